// File: rtl/serial_adder_fsm_if.sv
// Operand/result bundle for the bit-serial adder.
// Optional ovf signal exists only with SERIAL_ADD_OVF_EN.
interface serial_adder_fsm_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder, LSB first, one full_adder_mux per clock.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow flag.
module full_adder_mux (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = cin ? ~p : p;
  assign cout = p ? cin : a;
endmodule

module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_adder_fsm_if.slave io
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:1] res;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_s;
  logic             fa_co;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  full_adder_mux u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Result bits enter at the top; the oldest bit falls out
  // of res only when the full word is copied to sum.
  assign res_nxt = {fa_s, res};
  assign last    = (cnt == CW'(WIDTH - 1));

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.sum  = sum_q;
  assign io.cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  assign io.ovf = ovf_q;

  // Overflow flag: carry into MSB xor carry out of MSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_q <= carry ^ fa_co;
    end
  end
`endif

  // Control FSM, datapath shifting and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.start) begin
            sh_a   <= io.a;
            sh_b   <= io.b;
            carry  <= io.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          res   <= res_nxt[WIDTH-1:1];
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= res_nxt;
            cout_q <= fa_co;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench for serial_adder_fsm at WIDTH=8 and WIDTH=3.
// Directed vectors plus an exhaustive 3-bit sweep.
module tb_serial_adder_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_adder_fsm_if #(.WIDTH(8)) if8 ();
  serial_adder_fsm_if #(.WIDTH(3)) if3 ();

  serial_adder_fsm #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (if8.slave)
  );

  serial_adder_fsm #(.WIDTH(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (if3.slave)
  );

  int tests = 0;
  int fails = 0;
  int done3_cnt = 0;

  logic [8:0] q8[$];
  logic       q8o[$];
  logic [3:0] q3[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (if8.done === 1'b1) begin
      if (q8.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done8_unexpected: got done=1 expected none");
      end else begin
        logic [8:0] e;
        logic       eo;
        e  = q8.pop_front();
        eo = q8o.pop_front();
        chk("sum8", {24'd0, if8.sum}, {24'd0, e[7:0]});
        chk("cout8", {31'd0, if8.cout}, {31'd0, e[8]});
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf8", {31'd0, if8.ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("bad ovf entry");
`endif
      end
    end
  end

  // Monitor for the 3-bit instance
  always @(negedge clk) begin
    if (if3.done === 1'b1) begin
      done3_cnt++;
      if (q3.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done3_unexpected: got done=1 expected none");
      end else begin
        logic [3:0] e;
        e = q3.pop_front();
        chk("sum3", {28'd0, if3.cout, if3.sum}, {28'd0, e});
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    @(negedge clk);
    if8.a     = a;
    if8.b     = b;
    if8.cin   = c;
    if8.start = 1'b1;
  endtask

  task automatic wait_done8(output int lat, output int nb);
    lat = -1;
    nb  = 0;
    for (int k = 1; k <= 20; k++) begin
      if (if8.done === 1'b1) begin
        lat = k - 1;
        break;
      end
      if (if8.busy === 1'b1) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] es,
                      input logic ec, input logic eo);
    int lat;
    int nb;
    issue8(a, b, c);
    @(posedge clk);
    q8.push_back({ec, es});
    q8o.push_back(eo);
    @(negedge clk);
    if8.start = 1'b0;
    wait_done8(lat, nb);
    chk("latency8", lat, 8);
    chk("busy_cycles8", nb, 8);
    @(negedge clk);
    chk("done_pulse8", {31'd0, if8.done}, 0);
  endtask

  initial begin
    int lat;
    int nb;
    if8.start = 1'b0;
    if8.a     = '0;
    if8.b     = '0;
    if8.cin   = 1'b0;
    if3.start = 1'b0;
    if3.a     = '0;
    if3.b     = '0;
    if3.cin   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, if8.busy}, 0);
    chk("rst_done", {31'd0, if8.done}, 0);
    chk("rst_sum", {24'd0, if8.sum}, 0);
    chk("rst_cout", {31'd0, if8.cout}, 0);
    rst_n = 1'b1;

    run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Reset in the middle of RUN discards the operation
    issue8(8'h33, 8'h44, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, if8.busy}, 0);
    chk("midrst_done", {31'd0, if8.done}, 0);
    chk("midrst_sum", {24'd0, if8.sum}, 0);
    chk("midrst_cout", {31'd0, if8.cout}, 0);
    repeat (12) @(negedge clk);
    run8(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);

    // start held high: back-to-back ops spaced WIDTH+2
    issue8(8'h5A, 8'hA5, 1'b1);
    @(posedge clk);
    q8.push_back({1'b1, 8'h00});
    q8o.push_back(1'b0);
    @(negedge clk);
    wait_done8(lat, nb);
    chk("held_latency", lat, 8);
    chk("held_busy", nb, 8);
    @(negedge clk);
    chk("held_idle_busy", {31'd0, if8.busy}, 0);
    @(posedge clk);
    q8.push_back({1'b1, 8'h00});
    q8o.push_back(1'b0);
    @(negedge clk);
    chk("held_reaccept", {31'd0, if8.busy}, 1);
    if8.start = 1'b0;
    wait_done8(lat, nb);
    chk("held2_latency", lat, 8);

    // Exhaustive 3-bit sweep
    for (int i = 0; i < 128; i++) begin
      logic [2:0] a3;
      logic [2:0] b3;
      logic       c3;
      logic [3:0] e3;
      int         w;
      a3 = i[6:4];
      b3 = i[3:1];
      c3 = i[0];
      e3 = {1'b0, a3} + {1'b0, b3} + {3'd0, c3};
      @(negedge clk);
      if3.a     = a3;
      if3.b     = b3;
      if3.cin   = c3;
      if3.start = 1'b1;
      @(posedge clk);
      q3.push_back(e3);
      @(negedge clk);
      if3.start = 1'b0;
      w = 0;
      while (if3.done !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (w >= 10) begin
        tests++;
        fails++;
        $display("FAIL timeout3: got no done expected done");
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("done3_count", done3_cnt, 128);
    chk("q8_drained", q8.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
